// File: rtl/usb_line_pkg.sv
// Shared types and line-state encodings for the USB line transceiver.
package usb_line_pkg;

   typedef enum logic [1:0] {
      NONE      = 2'b00,
      TOKEN     = 2'b01,
      DATA      = 2'b10,
      HANDSHAKE = 2'b11
   } pkt_type_t;

   typedef enum logic [1:0] {T_IDLE, T_STREAM, T_SE0, T_J} tx_state_t;
   typedef enum logic [1:0] {R_IDLE, R_SEEK, R_DATA, R_EOP} rx_state_t;

   // Line states as {dp, dm}
   localparam logic [1:0] J   = 2'b10;
   localparam logic [1:0] K   = 2'b01;
   localparam logic [1:0] SE0 = 2'b00;
   localparam logic [1:0] SE1 = 2'b11;

endpackage

// File: rtl/usb_line_rx.sv
// Receive FSM: sync seek with timeout, bit counting, EOP qualification.
//   state  | meaning
//   R_IDLE | not listening
//   R_SEEK | armed, waiting for the first K of sync
//   R_DATA | packet bits arriving, counting received bits
//   R_EOP  | SE0 seen, waiting for the closing J
module usb_line_rx import usb_line_pkg::*; #(
   parameter int DATA_BITS  = 96,
   parameter int RX_TIMEOUT = 255,
   parameter int CW         = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic arm,
   input  logic abort,
   input  logic dp_r,
   input  logic dm_r,
   output logic tx_ok,
   output logic valid,
   output logic done,
   output logic err,
   output logic timeout
);

   localparam logic [CW-1:0] CMAX     = {CW{1'b1}};
   localparam logic [CW-1:0] TO_LAST  = CW'(RX_TIMEOUT - 1);
   localparam logic [CW-1:0] MAX_BITS = CW'(DATA_BITS);

   rx_state_t     state, nxt;
   logic [CW-1:0] cnt;
   logic [1:0]    line;

   assign line  = {dp_r, dm_r};
   assign tx_ok = (state == R_IDLE) || (state == R_SEEK);

   // cnt is the seek cycle count in R_SEEK and the received-bit count in R_DATA
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= R_IDLE;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if (state == R_SEEK && nxt == R_DATA)
            cnt <= CW'(1);
         else if (nxt != state)
            cnt <= '0;
         else if ((state == R_SEEK || state == R_DATA) && cnt != CMAX)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      nxt = state;
      case (state)
         R_IDLE: if (arm) nxt = R_SEEK;
         R_SEEK: begin
            if (abort)               nxt = R_IDLE;
            else if (line == K)      nxt = R_DATA;
            else if (cnt == TO_LAST) nxt = R_IDLE;
         end
         R_DATA: begin
            if (line == SE0)                         nxt = R_EOP;
            else if (line == SE1 || cnt >= MAX_BITS) nxt = R_IDLE;
         end
         R_EOP:   if (line != SE0) nxt = R_IDLE;
         default: nxt = R_IDLE;
      endcase
   end

   always_comb begin
      valid   = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      timeout = 1'b0;
      case (state)
         R_SEEK: begin
            if (!abort) begin
               if (line == K)           valid   = 1'b1;
               else if (cnt == TO_LAST) timeout = 1'b1;
            end
         end
         R_DATA: begin
            if (line == J || line == K) begin
               valid = 1'b1;
               err   = (cnt >= MAX_BITS);
            end else if (line == SE1) begin
               err = 1'b1;
            end
         end
         R_EOP: begin
            if (line == J)        done = 1'b1;
            else if (line != SE0) err  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/usb_line_xcvr.sv
// Half-duplex USB line transceiver: transmit FSM, tx/rx arbitration, receiver instance.
//   state    | meaning
//   T_IDLE   | line released, resting at J
//   T_STREAM | driving tx_bit for the latched packet length
//   T_SE0    | driving SE0 part of EOP
//   T_J      | driving J before release; tx_done on last cycle
module usb_line_xcvr import usb_line_pkg::*; #(
   parameter int TOK_BITS   = 32,
   parameter int DATA_BITS  = 96,
   parameter int HS_BITS    = 16,
   parameter int EOP_SE0    = 2,
   parameter int EOP_J      = 1,
   parameter int RX_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [1:0] tx_type,
   input  logic       tx_bit,
   output logic       tx_bit_req,
   output logic       tx_busy,
   output logic       tx_done,
   input  logic       rx_arm,
   input  logic       dp_r,
   input  logic       dm_r,
   output logic       dp_w,
   output logic       dm_w,
   output logic       line_oe,
   output logic       rx_bit,
   output logic       rx_valid,
   output logic       rx_done,
   output logic       rx_err,
   output logic       rx_timeout
);

   localparam int M1 = (DATA_BITS > RX_TIMEOUT) ? DATA_BITS : RX_TIMEOUT;
   localparam int M2 = (M1 > TOK_BITS) ? M1 : TOK_BITS;
   localparam int M3 = (M2 > HS_BITS) ? M2 : HS_BITS;
   localparam int CW = $clog2(M3 + 2);

   localparam logic [CW-1:0] CMAX     = {CW{1'b1}};
   localparam logic [CW-1:0] SE0_LAST = CW'(EOP_SE0 - 1);
   localparam logic [CW-1:0] J_LAST   = CW'(EOP_J - 1);

   tx_state_t     tx_state, tx_next;
   logic [CW-1:0] tx_cnt, tx_len, start_len;
   logic          tx_accept, tx_last, rx_tx_ok;

   assign tx_accept = (tx_state == T_IDLE) && tx_start && (tx_type != 2'b00) && rx_tx_ok;
   assign rx_bit    = dp_r;

   always_comb begin
      case (pkt_type_t'(tx_type))
         TOKEN:     start_len = CW'(TOK_BITS);
         DATA:      start_len = CW'(DATA_BITS);
         HANDSHAKE: start_len = CW'(HS_BITS);
         default:   start_len = '0;
      endcase
   end

   always_comb begin
      case (tx_state)
         T_STREAM: tx_last = (tx_cnt == tx_len - 1'b1);
         T_SE0:    tx_last = (tx_cnt == SE0_LAST);
         T_J:      tx_last = (tx_cnt == J_LAST);
         default:  tx_last = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= T_IDLE;
         tx_cnt   <= '0;
         tx_len   <= '0;
      end else begin
         tx_state <= tx_next;
         if (tx_accept)
            tx_len <= start_len;
         if (tx_state == T_IDLE || tx_next != tx_state)
            tx_cnt <= '0;
         else if (tx_cnt != CMAX)
            tx_cnt <= tx_cnt + 1'b1;
      end
   end

   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         T_IDLE:   if (tx_accept) tx_next = T_STREAM;
         T_STREAM: if (tx_last)   tx_next = T_SE0;
         T_SE0:    if (tx_last)   tx_next = T_J;
         T_J:      if (tx_last)   tx_next = T_IDLE;
         default:  tx_next = T_IDLE;
      endcase
   end

   always_comb begin
      dp_w       = 1'b1;
      dm_w       = 1'b0;
      tx_bit_req = 1'b0;
      tx_done    = 1'b0;
      tx_busy    = (tx_state != T_IDLE);
      case (tx_state)
         T_STREAM: begin
            dp_w       = tx_bit;
            dm_w       = ~tx_bit;
            tx_bit_req = 1'b1;
         end
         T_SE0: begin
            dp_w = 1'b0;
            dm_w = 1'b0;
         end
         T_J:     tx_done = tx_last;
         default: ;
      endcase
      line_oe = tx_busy;
   end

   // A tx_start accepted in the same cycle as rx_arm wins; the arm is dropped
   usb_line_rx #(
      .DATA_BITS  (DATA_BITS),
      .RX_TIMEOUT (RX_TIMEOUT),
      .CW         (CW)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .arm     (rx_arm & ~tx_busy & ~tx_accept),
      .abort   (tx_accept),
      .dp_r    (dp_r),
      .dm_r    (dm_r),
      .tx_ok   (rx_tx_ok),
      .valid   (rx_valid),
      .done    (rx_done),
      .err     (rx_err),
      .timeout (rx_timeout)
   );

endmodule

// File: tb/tb_usb_line_xcvr.sv
// Self-checking bench for usb_line_xcvr with a packet-level reference model.
module tb_usb_line_xcvr;

   localparam int TOK  = 32;
   localparam int DAT  = 96;
   localparam int HS   = 16;
   localparam int ESE0 = 2;
   localparam int EJ   = 1;
   localparam int TO   = 255;

   localparam logic [1:0] J_L   = 2'b10;
   localparam logic [1:0] K_L   = 2'b01;
   localparam logic [1:0] SE0_L = 2'b00;
   localparam logic [1:0] SE1_L = 2'b11;

   logic       clk = 1'b0;
   logic       rst, tx_start, tx_bit, rx_arm, dp_r, dm_r;
   logic [1:0] tx_type;
   logic       tx_bit_req, tx_busy, tx_done, dp_w, dm_w, line_oe;
   logic       rx_bit, rx_valid, rx_done, rx_err, rx_timeout;

   int passed = 0;
   int total  = 0;
   logic [1:0] seq[$];

   always #5 clk = ~clk;

   usb_line_xcvr #(
      .TOK_BITS(TOK), .DATA_BITS(DAT), .HS_BITS(HS),
      .EOP_SE0(ESE0), .EOP_J(EJ), .RX_TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst), .tx_start(tx_start), .tx_type(tx_type),
      .tx_bit(tx_bit), .tx_bit_req(tx_bit_req), .tx_busy(tx_busy),
      .tx_done(tx_done), .rx_arm(rx_arm), .dp_r(dp_r), .dm_r(dm_r),
      .dp_w(dp_w), .dm_w(dm_w), .line_oe(line_oe), .rx_bit(rx_bit),
      .rx_valid(rx_valid), .rx_done(rx_done), .rx_err(rx_err),
      .rx_timeout(rx_timeout)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int len_of(input int t);
      case (t)
         1:       return TOK;
         2:       return DAT;
         3:       return HS;
         default: return 0;
      endcase
   endfunction

   // Sends one packet; mode 0 = alternating bits, 1 = random. At cycle poke a
   // second tx_start and an rx_arm are raised (both must be ignored).
   task automatic send_pkt(input int typ, input int mode, input int poke, input logic arm0,
                           input string name);
      int len, tot;
      logic b;
      logic [5:0] got, expv;
      len = len_of(typ);
      tot = len + ESE0 + EJ;
      tick;
      tx_start = 1'b1; tx_type = typ[1:0]; rx_arm = arm0; tx_bit = 1'b0;
      #3;
      got = {dp_w, dm_w, line_oe, tx_busy, tx_bit_req, tx_done};
      total++;
      if (got !== 6'b100000) $display("FAIL %s idle_before: got %b expected %b", name, got, 6'b100000);
      else passed++;
      for (int c = 1; c <= tot; c++) begin
         tick;
         tx_start = (c == poke); tx_type = 2'b10; rx_arm = (c == poke);
         b = (mode == 0) ? c[0] : 1'($urandom_range(0, 1));
         tx_bit = b;
         #3;
         if (c <= len)             expv = {b, ~b, 1'b1, 1'b1, 1'b1, 1'b0};
         else if (c <= len + ESE0) expv = 6'b001100;
         else                      expv = {2'b10, 1'b1, 1'b1, 1'b0, (c == tot)};
         got = {dp_w, dm_w, line_oe, tx_busy, tx_bit_req, tx_done};
         total++;
         if (got !== expv) $display("FAIL %s cycle %0d: got %b expected %b", name, c, got, expv);
         else passed++;
      end
      tx_start = 1'b0; rx_arm = 1'b0;
   endtask

   task automatic mk_seq(input int pre, input int nbits, input int tail);
      seq.delete();
      repeat (pre) seq.push_back(J_L);
      seq.push_back(K_L);
      for (int b = 1; b < nbits; b++) seq.push_back($urandom_range(0, 1) ? J_L : K_L);
      case (tail)
         0: begin seq.push_back(SE0_L); seq.push_back(SE0_L); seq.push_back(J_L); end
         1: seq.push_back(SE1_L);
         2: begin seq.push_back(SE0_L); seq.push_back(K_L); end
         default: ;
      endcase
      seq.push_back(J_L); seq.push_back(K_L); seq.push_back(K_L); seq.push_back(J_L);
      seq.push_back(SE0_L); seq.push_back(SE0_L); seq.push_back(J_L); seq.push_back(K_L);
   endtask

   // Arms the receiver, plays seq, checks against the packet-level model.
   task automatic run_rx(input int poke, input string name);
      int n, k, i, bits;
      logic [3:0] ex[$];
      logic [8:0] got, expv;
      n = seq.size();
      for (i = 0; i < n; i++) ex.push_back(4'b0000);
      k = -1;
      for (i = 0; i < n && i < TO; i++)
         if (seq[i] == K_L) begin k = i; break; end
      if (k < 0) begin
         if (n >= TO) ex[TO-1] = 4'b0001;
      end else begin
         ex[k] = 4'b1000;
         bits = 1;
         i = k + 1;
         while (i < n) begin
            if (seq[i] == J_L || seq[i] == K_L) begin
               bits++;
               if (bits > DAT) begin ex[i] = 4'b1010; break; end
               ex[i] = 4'b1000;
               i++;
            end else if (seq[i] == SE1_L) begin
               ex[i] = 4'b0010;
               break;
            end else begin
               while (i < n && seq[i] == SE0_L) i++;
               if (i < n) ex[i] = (seq[i] == J_L) ? 4'b0100 : 4'b0010;
               break;
            end
         end
      end
      tick;
      rx_arm = 1'b1; {dp_r, dm_r} = J_L;
      #3;
      for (i = 0; i < n; i++) begin
         tick;
         rx_arm = 1'b0; tx_start = (i == poke); tx_type = 2'b01;
         {dp_r, dm_r} = seq[i];
         #3;
         got  = {rx_valid, rx_done, rx_err, rx_timeout, tx_busy, line_oe, dp_w, dm_w, rx_bit};
         expv = {ex[i], 2'b00, 2'b10, seq[i][1]};
         total++;
         if (got !== expv) $display("FAIL %s cycle %0d: got %b expected %b", name, i + 1, got, expv);
         else passed++;
      end
      tx_start = 1'b0;
      {dp_r, dm_r} = J_L;
   endtask

   task automatic test_reset;
      logic [9:0] got;
      rst = 1'b1;
      tick; tick;
      {dp_r, dm_r} = K_L;
      #3;
      got = {dp_w, dm_w, line_oe, tx_bit_req, tx_busy, tx_done, rx_valid, rx_done, rx_err, rx_timeout};
      total++;
      if (got !== 10'b1000000000) $display("FAIL reset_values: got %b expected %b", got, 10'b1000000000);
      else passed++;
      {dp_r, dm_r} = J_L;
      rst = 1'b0;
   endtask

   task automatic test_tx;
      send_pkt(1, 0, -1, 1'b0, "token_alt");
      send_pkt(2, 1, -1, 1'b0, "data_rand");
      send_pkt(3, 1, -1, 1'b0, "hs_rand");
   endtask

   task automatic test_back_to_back;
      send_pkt(3, 1, -1, 1'b0, "b2b_first");
      send_pkt(1, 1, -1, 1'b0, "b2b_second");
   endtask

   task automatic test_rx;
      mk_seq($urandom_range(0, 20), 16, 0);  run_rx(-1, "rx_good16");
      mk_seq($urandom_range(0, 20), $urandom_range(1, DAT), 0);  run_rx(-1, "rx_good_rand");
      mk_seq(3, DAT, 0);     run_rx(-1, "rx_max_len");
      mk_seq(2, DAT + 1, 0); run_rx(-1, "rx_overflow");
      mk_seq(5, 6, 1);       run_rx(-1, "rx_se1");
      mk_seq(1, 8, 2);       run_rx(-1, "rx_k_after_se0");
      seq.delete();
      repeat (TO + 5) seq.push_back(J_L);
      seq.push_back(K_L); seq.push_back(J_L);
      run_rx(-1, "rx_timeout");
   endtask

   task automatic test_ignored;
      send_pkt(1, 1, 5, 1'b0, "start_while_busy");
      tick; {dp_r, dm_r} = K_L; #3;
      total++;
      if (rx_valid !== 1'b0) $display("FAIL arm_while_busy: rx_valid %b expected 0", rx_valid);
      else passed++;
      {dp_r, dm_r} = J_L;
      send_pkt(3, 1, -1, 1'b1, "start_with_arm");
      tick; {dp_r, dm_r} = K_L; #3;
      total++;
      if (rx_valid !== 1'b0) $display("FAIL arm_with_start: rx_valid %b expected 0", rx_valid);
      else passed++;
      {dp_r, dm_r} = J_L;
      tick; tx_start = 1'b1; tx_type = 2'b00; #3;
      tick; tx_start = 1'b0; #3;
      total++;
      if ({tx_busy, line_oe, tx_bit_req, dp_w, dm_w} !== 5'b00010)
         $display("FAIL type_none: got %b expected %b", {tx_busy, line_oe, tx_bit_req, dp_w, dm_w}, 5'b00010);
      else passed++;
      mk_seq(4, 16, 0);
      run_rx(4 + 5, "start_during_data");
   endtask

   task automatic test_seek_abort;
      int seen;
      tick; rx_arm = 1'b1; {dp_r, dm_r} = J_L; #3;
      for (int c = 1; c <= 10; c++) begin
         tick; rx_arm = 1'b0; tx_start = (c == 10); tx_type = 2'b11; #3;
      end
      total++;
      if ({rx_valid, rx_timeout, tx_busy} !== 3'b000)
         $display("FAIL abort_cycle: got %b expected 000", {rx_valid, rx_timeout, tx_busy});
      else passed++;
      tick; tx_start = 1'b0; tx_bit = 1'b1; #3;
      total++;
      if ({tx_busy, tx_bit_req, line_oe} !== 3'b111)
         $display("FAIL abort_tx_started: got %b expected 111", {tx_busy, tx_bit_req, line_oe});
      else passed++;
      seen = 0;
      for (int c = 2; c <= TO + 30; c++) begin
         tick; #3;
         if (rx_timeout === 1'b1) seen++;
         if (c == HS + ESE0 + EJ) begin
            total++;
            if (tx_done !== 1'b1) $display("FAIL abort_tx_done: got %b expected 1", tx_done);
            else passed++;
         end
      end
      total++;
      if (seen != 0) $display("FAIL abort_no_timeout: got %0d pulses expected 0", seen);
      else passed++;
   endtask

   task automatic test_reset_mid;
      logic [9:0] got;
      tick; tx_start = 1'b1; tx_type = 2'b10; #3;
      for (int c = 1; c <= 20; c++) begin
         tick; tx_start = 1'b0; tx_bit = 1'($urandom_range(0, 1)); #3;
      end
      tick; rst = 1'b1; #3;
      tick; #3;
      got = {dp_w, dm_w, line_oe, tx_bit_req, tx_busy, tx_done, rx_valid, rx_done, rx_err, rx_timeout};
      total++;
      if (got !== 10'b1000000000) $display("FAIL reset_mid_tx: got %b expected %b", got, 10'b1000000000);
      else passed++;
      rst = 1'b0;
      send_pkt(3, 1, -1, 1'b0, "hs_after_reset");
      tick; rx_arm = 1'b1; {dp_r, dm_r} = J_L; #3;
      tick; rx_arm = 1'b0; {dp_r, dm_r} = K_L; #3;
      tick; {dp_r, dm_r} = J_L; #3;
      tick; {dp_r, dm_r} = K_L; rst = 1'b1; #3;
      tick; #3;
      got = {dp_w, dm_w, line_oe, tx_bit_req, tx_busy, tx_done, rx_valid, rx_done, rx_err, rx_timeout};
      total++;
      if (got !== 10'b1000000000) $display("FAIL reset_mid_rx: got %b expected %b", got, 10'b1000000000);
      else passed++;
      rst = 1'b0;
      tick; {dp_r, dm_r} = SE0_L; #3;
      tick; {dp_r, dm_r} = J_L; #3;
      total++;
      if ({rx_valid, rx_done, rx_err} !== 3'b000)
         $display("FAIL rx_idle_after_reset: got %b expected 000", {rx_valid, rx_done, rx_err});
      else passed++;
   endtask

   initial begin
      rst = 1'b1; tx_start = 1'b0; tx_type = 2'b00; tx_bit = 1'b0; rx_arm = 1'b0;
      {dp_r, dm_r} = J_L;
      test_reset;
      test_tx;
      test_back_to_back;
      test_rx;
      test_ignored;
      test_seek_abort;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/usb_line_xcvr.md
# usb_line_xcvr

Parametrised, half-duplex USB line transceiver between the bit-stuff/NRZI encode and decode pipeline and the DP/DM pins. It serialises a host bitstream onto DP/DM with per-packet-type lengths and a configurable EOP (SE0 then J), and receives device packets with sync detection, EOP qualification, line-error detection and a response timeout. It adds a start/done handshake, output-enable and bus arbitration between transmit and receive.

## Interface
- TOK_BITS, 32: token packet length in bit times, sync included.
- DATA_BITS, 96: data packet length in bit times; also the maximum accepted receive length.
- HS_BITS, 16: handshake packet length in bit times.
- EOP_SE0, 2: SE0 bit times driven at end of packet (≥1).
- EOP_J, 1: J bit times driven after SE0 before release (≥1).
- RX_TIMEOUT, 255: cycles in receive seek before a timeout is declared (≥1).
- clk  in  1  bit-rate clock.
- rst  in  1  synchronous, active-high reset.
- tx_start  in  1  one-cycle request to send a packet.
- tx_type  in  2  packet type, sampled with tx_start: 00 none, 01 token, 10 data, 11 handshake.
- tx_bit  in  1  current stream bit, consumed in every cycle with tx_bit_req=1.
- tx_bit_req  out  1  line is driving tx_bit this cycle; source advances next cycle.
- tx_busy  out  1  transmit in progress.
- tx_done  out  1  one-cycle pulse on the final J cycle.
- rx_arm  in  1  one-cycle request to wait for a device packet.
- dp_r, dm_r  in  1 each  line inputs.
- dp_w, dm_w  out  1 each  line outputs.
- line_oe  out  1  pad output enable.
- rx_bit  out  1  equals dp_r.
- rx_valid  out  1  rx_bit is a packet bit this cycle.
- rx_done  out  1  one-cycle pulse on a valid EOP.
- rx_err  out  1  one-cycle pulse on a line error.
- rx_timeout  out  1  one-cycle pulse when no sync arrives in time.

## Operation
- Line states: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1).
- TX FSM states: T_IDLE, T_STREAM, T_SE0, T_J.
  - T_IDLE: dp_w/dm_w = J, line_oe = 0.
  - tx_start with tx_type != 00, while rx is in R_IDLE or R_SEEK: the length is latched, the bit counter is cleared, and the FSM moves to T_STREAM. In all other cases tx_start is ignored. This includes tx_type 00, tx_busy = 1, and rx in R_DATA or R_EOP.
  - T_STREAM: dp_w = tx_bit, dm_w = ~tx_bit, tx_bit_req = 1, line_oe = 1. The counter goes to T_SE0 after exactly the latched length cycles.
  - T_SE0 lasts EOP_SE0 cycles and drives SE0. T_J lasts EOP_J cycles and drives J. tx_done pulses on the last T_J cycle, then the FSM returns to T_IDLE.
  - tx_busy = 1 in every state except T_IDLE. line_oe = tx_busy.
- RX FSM states: R_IDLE, R_SEEK, R_DATA, R_EOP.
  - R_IDLE goes to R_SEEK on rx_arm when tx_busy = 0. If tx_start is accepted in the same cycle, tx wins and rx_arm is dropped.
  - R_SEEK: a K on the line moves to R_DATA, and rx_valid = 1 in that cycle (first sync bit). The timeout counter increments each cycle. Reaching RX_TIMEOUT pulses rx_timeout and returns to R_IDLE. An accepted tx_start aborts silently to R_IDLE.
  - R_DATA: rx_valid = 1 on J or K. The received-bit count increments.
    - SE0 moves to R_EOP.
    - SE1, or a count exceeding DATA_BITS, pulses rx_err and returns to R_IDLE.
  - R_EOP: SE0 stays in R_EOP. J pulses rx_done and returns to R_IDLE. K or SE1 pulses rx_err and returns to R_IDLE.
  - rx_valid = 0 in R_IDLE and R_EOP.
- Counters are sized for max(DATA_BITS, RX_TIMEOUT) + 1 and never wrap; they saturate at their terminal value.

## Timing
- Reset values:
  - states: T_IDLE, R_IDLE.
  - dp_w = 1, dm_w = 0.
  - line_oe, tx_bit_req, tx_busy, tx_done = 0.
  - rx_valid, rx_done, rx_err, rx_timeout = 0.
  - All counters = 0.
- Reset asserted mid-packet returns to the reset values on the next edge. No done or error pulse is emitted.
- TX latency: tx_start at cycle 0 puts the first stream bit on the line at cycle 1. A token spans cycles 1–32 (stream), 33–34 (SE0) and 35 (J); tx_done is 1 at cycle 35.
- tx_start may be accepted in the cycle after tx_done.
- RX outputs are combinational from dp_r/dm_r and the current state. rx_done, rx_err and rx_timeout are asserted in the cycle of the triggering line state.

## Structure
- Package usb_line_pkg contains:
  - pkt_type_t enum (NONE, TOKEN, DATA, HANDSHAKE).
  - tx_state_t and rx_state_t enums.
  - Line-state constants J, K, SE0 and SE1.
- Sub-module usb_line_rx holds the receive FSM and the timeout/length counters. The transmit FSM and arbitration stay in usb_line_xcvr.

## Test plan
- Token (tx_type = 01) with tx_bit alternating 1/0: 32 cycles of J/K matching tx_bit, then 2 SE0, then 1 J with tx_done = 1. line_oe is 1 for 35 cycles, after which the line rests at J.
- rx_arm followed by device K, 15 J/K bits, SE0, SE0, J: rx_valid is high for 16 cycles, then rx_done pulses on the J and no error is raised.
- rx_arm with no K for 255 cycles: rx_timeout pulses on cycle 255 and the FSM returns to R_IDLE.
- SE1 mid-packet, or K after SE0: rx_err pulses and the receiver ignores further line activity until the next rx_arm.
- tx_start during tx_busy, tx_start with type 00, and tx_start during R_DATA are all ignored. tx_start during R_SEEK is accepted and aborts the receive with no rx_timeout.
- rst asserted mid-data-packet: next cycle all outputs are at reset values; a subsequent handshake sends 16 stream bits and completes normally.
